ext_int_ctrl: RTL and testbench
===============================

# ext_int_ctrl

External interrupt controller: collects up to NUM_SRC asynchronous device interrupt lines and arbitrates them by programmable priority. Presents one request on the core's `int_flag` input to the clint, with a claim/complete handshake over the peripheral bus. Sits between the peripherals and the core, beside the timer, as a single bus slave.

## Interface
Parameters:
- NUM_SRC, 8: number of sources, 1..31; IDs are 1..NUM_SRC, 0 = none.
- PRIO_W, 3: priority width; priority 0 = source never interrupts.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- src_i  in  NUM_SRC  raw device interrupt lines, asynchronous, rising-edge meaningful.
- we_i  in  1  bus write strobe.
- re_i  in  1  bus read strobe.
- addr_i  in  MemAddrBus  byte address; only addr_i[7:2] decoded.
- data_i  in  RegBus  write data.
- data_o  out  RegBus  read data, registered.
- int_flag_o  out  INT_BUS  to clint `int_flag_i`; INT_EXT when asserted, else INT_NONE.

## Operation
Register map, word offsets:
- 0x00 ENABLE (RW): bit i-1 enables source i.
- 0x04 PENDING (RO): bit i-1 = pending[i].
- 0x08 THRESHOLD (RW, PRIO_W bits).
- 0x0C CLAIM (read) / COMPLETE (write).
- 0x40+4*(i-1) PRIORITY[i] (RW, PRIO_W bits).
- Unmapped reads return 0; unmapped writes are ignored; written data is truncated to field width.

Per-source gateway:
- 2-flop synchronizer, then rising-edge detect.
- Edge while not pending and not in-service: sets pending.
- Edge while already pending: merged, no second pending.
- Edge while in-service: dropped.

Arbiter:
- Eligible = pending & enabled & priority > THRESHOLD.
- Winner = highest priority; ties go to the lowest ID.
- best_id and best_prio are registered each cycle.
- int_flag_o = INT_EXT iff registered best_id != 0.

Claim: re_i at 0x0C.
- Returns registered best_id.
- If nonzero, clears pending[id] and sets in_service[id] on the same edge.
- If best_id = 0, returns 0 with no state change.

Complete: we_i at 0x0C with data_i = id.
- Clears in_service[id] if set.
- id of 0, out of range, or not in service: ignored.

Other rules:
- Disabling a source does not clear its pending bit.
- Simultaneous claim of id and an edge on id: claim wins, the edge is dropped.
- Simultaneous complete of id and an edge on id: the edge is dropped.

## Timing
- Reset: data_o = 0, int_flag_o = INT_NONE. ENABLE, PENDING, in_service, THRESHOLD, all PRIORITY and the synchronizers all clear.
- Reset asserted mid-claim or in-service clears everything at the next clk_i edge; no interrupt survives reset.
- src_i high sampled at edge N: pending set at edge N+3, best_id registered at N+4, int_flag_o asserted after N+4.
- Read data: data_o valid the cycle after re_i. data_o holds its value when re_i is low.
- Claim side effects occur on the re_i edge. int_flag_o deasserts two cycles later if nothing else is eligible. Software must not re-claim within 2 cycles; such a claim returns 0.
- Register writes take effect on the we_i edge and are visible to the arbiter in the next registered best_id.
- we_i and re_i in the same cycle: the write is applied and the read returns pre-write data.

## Structure
- tinyriscv_pkg additions:
  - INT_EXT constant in INT_BUS width.
  - Register offset localparams: EIC_ENABLE, EIC_PENDING, EIC_THRESHOLD, EIC_CLAIM, EIC_PRIO_BASE.
- Sub-module ext_int_gateway, one instance per source: synchronizer, edge detect, pending and in-service flops. Inputs: claim and complete strobes. Outputs: pending, in_service.
- The arbiter is a priority-compare loop in the top; no separate module.

## Test plan
- Reset, then read every register: all 0, int_flag_o = INT_NONE.
- PRIORITY[3]=5, ENABLE=0x04, THRESHOLD=0, pulse src_i[2]: int_flag_o = INT_EXT at N+4. CLAIM returns 3, PENDING=0, int_flag_o low 2 cycles later. COMPLETE 3 clears in_service.
- Sources 2 and 5 both at priority 4 and enabled, pulsed together: claims return 2 then 5. Set PRIORITY[5]=6 and repeat: claims return 5 then 2.
- THRESHOLD=4, PRIORITY[1]=4, source 1 pulsed: pending=1, no int_flag_o. Write THRESHOLD=3: int_flag_o asserts, claim returns 1.
- Source 1 claimed and not completed, pulsed twice more: PENDING stays 0. COMPLETE 1, then pulse: pending sets. COMPLETE 7 with 7 not in service: no change.
- Pulse src_i[0] in the same cycle as CLAIM of id 1: claim returns 1, no new pending. Reset asserted while source 1 is in service: everything clears at the next edge.

Source files
------------

// File: rtl/ext_int_ctrl_pkg.sv
// Shared bus widths, interrupt codes and register offsets for the external
// interrupt controller.
package ext_int_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int REG_W      = 32;
  localparam int INT_W      = 8;

  localparam logic [INT_W-1:0] INT_NONE = 8'h00;
  localparam logic [INT_W-1:0] INT_EXT  = 8'h02;

  // Byte offsets within the controller window; only bits [7:2] are decoded.
  localparam logic [7:0] EIC_ENABLE    = 8'h00;
  localparam logic [7:0] EIC_PENDING   = 8'h04;
  localparam logic [7:0] EIC_THRESHOLD = 8'h08;
  localparam logic [7:0] EIC_CLAIM     = 8'h0C;
  localparam logic [7:0] EIC_PRIO_BASE = 8'h40;

endpackage

// File: rtl/ext_int_ctrl_gateway.sv
// Per-source gateway: synchronizes an asynchronous line, detects rising
// edges and tracks pending / in-service state for one interrupt source.
module ext_int_gateway
  import ext_int_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic in_service_o
);

  logic sync1_q, sync2_q, prev_q, edge_q;
  logic pending_q, pending_d;
  logic in_service_q, in_service_d;

  // A claim always wins over a same-cycle edge; edges arriving while the
  // source is in service (including the completing cycle) are dropped.
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (claim_i) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else begin
      if (edge_q && !in_service_q) pending_d = 1'b1;
      if (complete_i) in_service_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      edge_q       <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      sync1_q      <= src_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      edge_q       <= sync2_q & ~prev_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-source gateways, a priority arbiter and
// a bus register file with claim/complete handshake toward the clint.
module ext_int_ctrl
  import ext_int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_SRC-1:0]    src_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic [REG_W-1:0]      data_i,
  output logic [REG_W-1:0]      data_o,
  output logic [INT_W-1:0]      int_flag_o
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC-1:0] enable_q, pending, in_service, claim_vec, complete_vec;
  logic [PRIO_W-1:0]  thr_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [ID_W-1:0]    best_id_q, best_id_c;
  logic [PRIO_W-1:0]  best_prio_q, best_prio_c;
  logic [REG_W-1:0]   data_q, rdata_c;
  logic [7:0]         offs;
  logic               claim_sel, claim_ok;
  logic               unused_addr;

  assign offs        = {addr_i[7:2], 2'b00};
  assign claim_sel   = (offs == EIC_CLAIM);
  assign unused_addr = ^{addr_i[MEM_ADDR_W-1:8], addr_i[1:0]};

  // A claim only succeeds while the registered winner is still pending, so a
  // re-claim before best_id refreshes returns 0 instead of a stale ID.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign claim_vec[g]    = re_i && claim_sel && (best_prio_q != '0) &&
                             (best_id_q == ID_W'(g + 1)) && pending[g];
    assign complete_vec[g] = we_i && claim_sel && (data_i == REG_W'(g + 1));

    ext_int_gateway u_gw (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .src_i        (src_i[g]),
      .claim_i      (claim_vec[g]),
      .complete_i   (complete_vec[g]),
      .pending_o    (pending[g]),
      .in_service_o (in_service[g])
    );
  end

  assign claim_ok = |claim_vec;

  // Strict compare keeps the lowest ID on priority ties.
  always_comb begin
    best_id_c   = '0;
    best_prio_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && enable_q[i] && (prio_q[i] > thr_q) && (prio_q[i] > best_prio_c)) begin
        best_id_c   = ID_W'(i + 1);
        best_prio_c = prio_q[i];
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (offs == EIC_ENABLE) begin
      rdata_c[NUM_SRC-1:0] = enable_q;
    end else if (offs == EIC_PENDING) begin
      rdata_c[NUM_SRC-1:0] = pending;
    end else if (offs == EIC_THRESHOLD) begin
      rdata_c[PRIO_W-1:0] = thr_q;
    end else if (claim_sel) begin
      if (claim_ok) rdata_c[ID_W-1:0] = best_id_q;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (offs == EIC_PRIO_BASE + 8'(4 * i)) rdata_c[PRIO_W-1:0] = prio_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      enable_q    <= '0;
      thr_q       <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      data_q      <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else begin
      best_id_q   <= best_id_c;
      best_prio_q <= best_prio_c;
      if (re_i) data_q <= rdata_c;
      if (we_i) begin
        if (offs == EIC_ENABLE)    enable_q <= data_i[NUM_SRC-1:0];
        if (offs == EIC_THRESHOLD) thr_q    <= data_i[PRIO_W-1:0];
        for (int i = 0; i < NUM_SRC; i++) begin
          if (offs == EIC_PRIO_BASE + 8'(4 * i)) prio_q[i] <= data_i[PRIO_W-1:0];
        end
      end
    end
  end

  assign data_o     = data_q;
  assign int_flag_o = (best_id_q != '0) ? INT_EXT : INT_NONE;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl with a cycle-level reference model and
// per-cycle output comparison.
module tb_ext_int_ctrl;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam logic [31:0] CLM = 32'h0C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  src = '0;
  logic          we = 1'b0, re = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [31:0]   rdata;
  logic [7:0]    flag;
  logic [31:0]   v;
  bit            chk_en = 1'b0;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  ext_int_ctrl #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .src_i      (src),
    .we_i       (we),
    .re_i       (re),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (rdata),
    .int_flag_o (flag)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as the rules describe it, inputs seen 3 edges late.
  bit [N:1]    m_pend, m_isv, m_en, ev, n_pend, n_isv;
  int          m_thr, m_best, nb, off, cid;
  int          m_prio [1:N];
  bit [31:0]   m_data;
  bit [N-1:0]  h0, h1, h2, h3;

  function automatic int arb();
    for (int p = (1 << PW) - 1; p > m_thr; p--)
      for (int id = 1; id <= N; id++)
        if (m_pend[id] && m_en[id] && m_prio[id] == p) return id;
    return 0;
  endfunction

  function automatic bit [31:0] mread(int o, int claim_val);
    if (o == 'h00) return 32'(m_en);
    if (o == 'h04) return 32'(m_pend);
    if (o == 'h08) return 32'(m_thr);
    if (o == 'h0C) return 32'(claim_val);
    if (o >= 'h40 && o < 'h40 + 4 * N) return 32'(m_prio[(o - 'h40) / 4 + 1]);
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = '0; m_isv = '0; m_en = '0; m_thr = 0; m_best = 0; m_data = '0;
      h0 = '0; h1 = '0; h2 = '0; h3 = '0;
      for (int id = 1; id <= N; id++) m_prio[id] = 0;
    end else begin
      off = int'(addr[7:0]) & 'hFC;
      cid = (m_best != 0 && m_pend[m_best]) ? m_best : 0;
      nb  = arb();
      if (re) m_data = mread(off, cid);
      n_pend = m_pend;
      n_isv  = m_isv;
      for (int id = 1; id <= N; id++) begin
        ev[id] = h2[id-1] & ~h3[id-1];
        if (re && off == 'h0C && cid == id) begin
          n_pend[id] = 1'b0;
          n_isv[id]  = 1'b1;
        end else begin
          if (ev[id] && !m_isv[id]) n_pend[id] = 1'b1;
          if (we && off == 'h0C && wdata == 32'(id)) n_isv[id] = 1'b0;
        end
      end
      if (we) begin
        if (off == 'h00) m_en = wdata[N-1:0];
        if (off == 'h08) m_thr = int'(wdata[PW-1:0]);
        if (off >= 'h40 && off < 'h40 + 4 * N) m_prio[(off - 'h40) / 4 + 1] = int'(wdata[PW-1:0]);
      end
      m_pend = n_pend;
      m_isv  = n_isv;
      m_best = nb;
      h3 = h2; h2 = h1; h1 = h0; h0 = src;
    end
  end

  initial begin
    wait (chk_en);
    forever begin
      @(posedge clk);
      #1;
      chk("data_o", rdata, m_data);
      chk("int_flag_o", 32'(flag), (m_best != 0) ? 32'h02 : 32'h00);
    end
  end

  // All tasks start and end at a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    src = m;
    @(negedge clk);
    src = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    chk_en = 1'b1;
    chk("rst data_o", rdata, 32'h0);
    chk("rst flag", 32'(flag), 32'h0);
    rst_n = 1'b1;
    foreach (m_prio[id]) begin
      rd(32'h40 + 32'(4 * (id - 1)), v);
      chk("rst prio", v, 32'h0);
    end
    for (int a = 0; a < 16; a += 4) begin
      rd(32'(a), v);
      chk("rst reg", v, 32'h0);
    end

    // single source, latency and claim/complete
    wr(32'h48, 5); wr(32'h00, 32'h04); wr(32'h08, 0);
    src = 8'h04;
    @(negedge clk);
    src = '0;
    idle(3);
    chk("flag at N+3", 32'(flag), 32'h00);
    idle(1);
    chk("flag at N+4", 32'(flag), 32'h02);
    rd(CLM, v); chk("claim 3", v, 32'd3);
    rd(32'h04, v); chk("pending after claim", v, 32'h0);
    idle(1);
    chk("flag after claim", 32'(flag), 32'h00);
    wr(CLM, 3);
    pulse(8'h04); idle(5);
    rd(32'h04, v); chk("pending after complete", v, 32'h04);
    rd(CLM, v); chk("claim 3 again", v, 32'd3);
    wr(CLM, 3);

    // equal priority tie, then raised priority
    wr(32'h44, 4); wr(32'h50, 4); wr(32'h00, 32'h12);
    pulse(8'h12); idle(5);
    rd(CLM, v); chk("tie claim 2", v, 32'd2);
    rd(CLM, v); chk("early reclaim", v, 32'd0);
    idle(2);
    rd(CLM, v); chk("tie claim 5", v, 32'd5);
    wr(CLM, 2); wr(CLM, 5);
    wr(32'h50, 6);
    pulse(8'h12); idle(5);
    rd(CLM, v); chk("prio claim 5", v, 32'd5);
    idle(2);
    rd(CLM, v); chk("prio claim 2", v, 32'd2);
    wr(CLM, 2); wr(CLM, 5);

    // threshold masking
    wr(32'h08, 4); wr(32'h40, 4); wr(32'h00, 32'h01);
    pulse(8'h01); idle(5);
    rd(32'h04, v); chk("pending at thr", v, 32'h01);
    chk("no flag at thr", 32'(flag), 32'h00);
    wr(32'h08, 3); idle(1);
    chk("flag after thr", 32'(flag), 32'h02);
    rd(CLM, v); chk("claim 1", v, 32'd1);
    addr = 32'h08; wdata = 32'd5; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    chk("rw old data", rdata, 32'd3);
    rd(32'h08, v); chk("rw new data", v, 32'd5);
    wr(32'h08, 3);

    // in-service drops edges; bad completes ignored
    pulse(8'h01); idle(2); pulse(8'h01); idle(5);
    rd(32'h04, v); chk("edges while in service", v, 32'h0);
    wr(CLM, 1);
    pulse(8'h01); idle(5);
    rd(32'h04, v); chk("pending after complete 1", v, 32'h01);
    wr(CLM, 7); wr(CLM, 0); idle(1);
    rd(32'h04, v); chk("bad complete", v, 32'h01);
    wr(32'h00, 32'hFFFF_FF01);
    rd(32'h00, v); chk("enable truncated", v, 32'h01);
    rd(32'h10, v); chk("unmapped", v, 32'h0);
    rd(32'h60, v); chk("prio out of range", v, 32'h0);
    rd(32'h1000_0040, v); chk("upper addr ignored", v, 32'd4);

    // edge reaching the gateway on the claim edge is dropped
    src = 8'h01;
    @(negedge clk);
    src = '0;
    idle(2);
    rd(CLM, v); chk("claim with edge", v, 32'd1);
    idle(5);
    rd(32'h04, v); chk("edge on claim dropped", v, 32'h0);

    // reset while source 1 in service
    rd(32'h00, v);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset data_o", rdata, 32'h0);
    chk("reset flag", 32'(flag), 32'h0);
    rst_n = 1'b1;
    rd(32'h00, v); chk("reset enable", v, 32'h0);
    pulse(8'h01); idle(5);
    rd(32'h04, v); chk("in service cleared", v, 32'h01);
    chk("disabled no flag", 32'(flag), 32'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
